// File: rtl/wb_mem_loader.sv
// wb_mem_loader
//   Wishbone classic slave that streams words into the core's memory while
//   holding the core in reset. Software selects a start address (ADDR),
//   writes words to DATA, and each word is queued with its address in a small
//   FIFO. The FIFO head is presented to the SRAM stage with a valid/ready
//   handshake.
//
//   Register map (word offsets inside the 32-byte window at BASE_ADDR):
//     0 CTRL   rw  bit0 LOAD, bit1 HOLD (HOLD resets to 1)
//     1 ADDR   rw  [19:0] next load word address
//     2 DATA   wo  push {ADDR, data}; reads 0
//     3 STATUS ro  [4:0] occupancy, 8 empty, 9 full, 10 busy, 11 DROP
//     4 CSUM   ro  wrapping sum of popped words (only with WB_MEM_LOADER_CSUM_EN)
//
//   Optional feature: define WB_MEM_LOADER_CSUM_EN to build the CSUM register;
//   without it, select 4 reads 0.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i       Wishbone control
//   wbs_adr_i, wbs_dat_i             Wishbone byte address / write data
//   wbs_ack_o, wbs_dat_o             registered acknowledge / read data
//   is_loading_memory_into_core      load-mode flag to the SRAM stage
//   reset_core                       core hold-reset (HOLD | LOAD)
//   addr_to_core_mem, data_to_core_mem, load_valid, load_ready
//                                    FIFO head handshake to the SRAM stage
module wb_mem_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        is_loading_memory_into_core,
    output logic        reset_core,
    output logic [19:0] addr_to_core_mem,
    output logic [31:0] data_to_core_mem,
    output logic        load_valid,
    input  logic        load_ready
);

    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOADING, DRAIN} state_t;
    state_t state, state_next;

    logic [19:0]   addr_reg;
    logic          hold;
    logic          drop;
    logic [31:0]   rd_data;
    logic [31:0]   status;
    logic [31:0]   csum_rd;

    logic [19:0]   mem_addr [FIFO_DEPTH];
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count, count_next;
    logic          fifo_empty, fifo_full;

    logic          hit, accept, stall, loading;
    logic [2:0]    reg_sel;
    logic          ctrl_wr, addr_wr, data_wr, push, pop;

    // Byte selects are deliberately ignored and the low address bits carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign reg_sel    = wbs_adr_i[4:2];
    assign loading    = (state == LOADING);
    assign fifo_empty = (count == 5'd0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign load_valid = (state != IDLE) & ~fifo_empty;
    assign pop        = load_valid & load_ready;

    // A full FIFO only blocks a DATA write that would actually push; a pop in
    // the same cycle frees the slot, so the write goes through.
    assign stall   = hit & wbs_we_i & (reg_sel == 3'd2) & loading & fifo_full & ~pop;
    assign accept  = hit & ~wbs_ack_o & ~stall;
    assign ctrl_wr = accept & wbs_we_i & (reg_sel == 3'd0);
    assign addr_wr = accept & wbs_we_i & (reg_sel == 3'd1);
    assign data_wr = accept & wbs_we_i & (reg_sel == 3'd2);
    assign push    = data_wr & loading;

    assign count_next = count + {4'b0, push} - {4'b0, pop};

    assign is_loading_memory_into_core = (state != IDLE);
    assign reset_core                  = hold | is_loading_memory_into_core;
    assign addr_to_core_mem            = mem_addr[rd_ptr];
    assign data_to_core_mem            = mem_data[rd_ptr];

    // FSM: leaving LOADING/DRAIN looks at post-update occupancy so LOAD falls
    // on the same edge that pops the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_wr && wbs_dat_i[0]) state_next = LOADING;
            LOADING: if (ctrl_wr && !wbs_dat_i[0])
                         state_next = (count_next == 5'd0) ? IDLE : DRAIN;
            DRAIN:   if (ctrl_wr && wbs_dat_i[0]) state_next = LOADING;
                     else if (count_next == 5'd0)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            hold     <= 1'b1;
            drop     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                hold <= wbs_dat_i[1];
                drop <= 1'b0;
            end
            if (data_wr && !loading) drop <= 1'b1;
            if (addr_wr)   addr_reg <= wbs_dat_i[19:0];
            else if (push) addr_reg <= addr_reg + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= addr_reg;
            mem_data[wr_ptr] <= wbs_dat_i;
        end
    end

`ifdef WB_MEM_LOADER_CSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     csum <= '0;
        else if (ctrl_wr && wbs_dat_i[0] && state == IDLE) csum <= '0;
        else if (pop)                                   csum <= csum + data_to_core_mem;
    end
    assign csum_rd = csum;
`else
    assign csum_rd = '0;
`endif

    assign status = {20'b0, drop, ~fifo_empty, fifo_full, fifo_empty, 3'b0, count};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data = {30'b0, hold, is_loading_memory_into_core};
            3'd1:    rd_data = {12'b0, addr_reg};
            3'd3:    rd_data = status;
            3'd4:    rd_data = csum_rd;
            default: rd_data = '0;
        endcase
    end

    // Read data is registered alongside ack and cleared otherwise, so the bus
    // sees zero whenever ack is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept && !wbs_we_i) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_wb_mem_loader.sv
// Self-checking bench for wb_mem_loader: directed scenarios plus a randomized
// phase, checked against a queue-based model of the loader's register rules.
module tb_wb_mem_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, dat_in = '0;
    logic        ack;
    logic [31:0] dat_out;
    logic        is_loading, reset_core, load_valid;
    logic        load_ready = 1'b0;
    logic [19:0] mem_addr;
    logic [31:0] mem_data;

    wb_mem_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_in),
        .wbs_ack_o(ack), .wbs_dat_o(dat_out),
        .is_loading_memory_into_core(is_loading), .reset_core(reset_core),
        .addr_to_core_mem(mem_addr), .data_to_core_mem(mem_data),
        .load_valid(load_valid), .load_ready(load_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [51:0] mq[$];
    logic [19:0] m_addr;
    logic        m_load_req, m_drain, m_hold, m_drop;
    logic [31:0] m_csum;
    int          pop_count = 0;
    logic        mon_en = 1'b0;

    function automatic void model_reset();
        mq.delete();
        m_addr = '0; m_load_req = 1'b0; m_drain = 1'b0;
        m_hold = 1'b1; m_drop = 1'b0; m_csum = '0;
    endfunction

    function automatic logic m_loading();
        return m_load_req | m_drain;
    endfunction

    function automatic logic [31:0] m_status();
        int n = mq.size();
        return {20'b0, m_drop, n != 0, n == DEPTH, n == 0, 3'b0, 5'(n)};
    endfunction

    function automatic void model_write(input int rsel, input logic [31:0] d);
        case (rsel)
            0: begin
                if (d[0] && !m_loading()) m_csum = '0;
                m_hold = d[1];
                m_drop = 1'b0;
                if (d[0]) begin
                    m_load_req = 1'b1; m_drain = 1'b0;
                end else if (m_load_req) begin
                    m_load_req = 1'b0; m_drain = (mq.size() != 0);
                end
            end
            1: m_addr = d[19:0];
            2: if (m_load_req) begin
                   mq.push_back({m_addr, d});
                   m_addr = m_addr + 20'd1;
               end else m_drop = 1'b1;
            default: ;
        endcase
    endfunction

    // ---------------- load_ready driver ----------------
    logic rdy_random = 1'b0, rdy_fixed = 1'b0;
    always @(posedge clk) begin
        #1;
        load_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic set_ready(input logic rnd, input logic val);
        rdy_random = rnd; rdy_fixed = val;
        @(posedge clk); #2;
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [51:0] e;
            check("is_loading", 32'(is_loading), 32'(m_loading()));
            check("reset_core", 32'(reset_core), 32'(m_hold | m_loading()));
            check("load_valid", 32'(load_valid), 32'(m_loading() && mq.size() > 0));
            if (!ack) check("dat_idle", dat_out, 32'h0);
            if (load_valid && load_ready && mq.size() > 0) begin
                e = mq.pop_front();
                check("pop_addr", 32'(mem_addr), 32'(e[51:32]));
                check("pop_data", mem_data, e[31:0]);
                m_csum = m_csum + e[31:0];
                pop_count++;
                if (mq.size() == 0) m_drain = 1'b0;
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(posedge clk); #1;
        adr = a; we = w; dat_in = d;
        sel = (w && $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'hF;
        stb = 1'b1; cyc = 1'b1;
    endtask

    task automatic bus_wait(input int limit, output logic got, output logic [31:0] rdata);
        got = 1'b0; rdata = '0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; rdata = dat_out; break; end
        end
    endtask

    task automatic bus_release();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input int rsel, input logic [31:0] d);
        logic got; logic [31:0] rd;
        bus_drive(BASE | 32'(rsel << 2), 1'b1, d);
        bus_wait(100, got, rd);
        bus_release();
        if (!got) check("wr_timeout", 32'(got), 32'h1);
        else model_write(rsel, d);
    endtask

    task automatic wb_read(input int rsel, input logic [31:0] exp, input string tag);
        logic got; logic [31:0] rd;
        bus_drive(BASE | 32'(rsel << 2), 1'b0, 32'h0);
        bus_wait(100, got, rd);
        bus_release();
        if (!got) check({tag, "_timeout"}, 32'(got), 32'h1);
        else check(tag, rd, exp);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((mq.size() != 0 || m_drain) && n < 300) begin
            @(posedge clk); n++;
        end
        #2;
        check("drain_done", 32'(mq.size()), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic got;
        logic [31:0] rd;
        int p0, acks;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        check("rst_reset_core", 32'(reset_core), 32'h1);
        check("rst_is_loading", 32'(is_loading), 32'h0);
        check("rst_load_valid", 32'(load_valid), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", dat_out, 32'h0);
        #1 mon_en = 1'b1;
        wb_read(3, 32'h0000_0100, "status_reset");
        wb_read(0, 32'h0000_0002, "ctrl_reset");

        // single word
        set_ready(1'b0, 1'b1);
        p0 = pop_count;
        wb_write(0, 32'h1);
        wb_write(1, 32'h0001_0);
        wb_write(2, 32'hDEAD_BEEF);
        wait_drain();
        check("single_pops", 32'(pop_count - p0), 32'h1);
        wb_read(1, 32'h0000_0011, "addr_after_one");

        // full FIFO stall
        set_ready(1'b0, 1'b0);
        p0 = pop_count;
        for (int i = 0; i < DEPTH; i++) wb_write(2, 32'hA500_0000 + 32'(i));
        wb_read(3, 32'h0000_0604, "status_full");
        bus_drive(BASE | 32'h8, 1'b1, 32'hA500_0004);
        bus_wait(6, got, rd);
        check("stall_noack", 32'(got), 32'h0);
        set_ready(1'b0, 1'b1);
        bus_wait(20, got, rd);
        bus_release();
        check("stall_ack", 32'(got), 32'h1);
        if (got) model_write(2, 32'hA500_0004);
        wait_drain();
        check("stall_pops", 32'(pop_count - p0), 32'h5);

        // address wrap
        wb_write(1, 32'h000F_FFFF);
        wb_write(2, 32'h1111_1111);
        wb_write(2, 32'h2222_2222);
        wait_drain();
        wb_read(1, 32'h0000_0001, "addr_wrap");

        // drain after LOAD cleared, DROP on late DATA
        set_ready(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) wb_write(2, $urandom);
        wb_write(0, 32'h0);
        check("drain_loading", 32'(is_loading), 32'h1);
        wb_write(2, 32'hBAD0_BAD0);
        wb_read(3, m_status(), "status_drop");
        check("drop_bit_model", 32'(m_status() >> 11), 32'h1);
        set_ready(1'b0, 1'b1);
        wait_drain();
        @(negedge clk);
        check("drain_end", 32'(is_loading), 32'h0);

        // non-hit accesses
        bus_drive(BASE + 32'h20, 1'b0, 32'h0);
        bus_wait(5, got, rd);
        bus_release();
        check("nohit_ack", 32'(got), 32'h0);
        bus_drive(32'h4000_0000, 1'b1, 32'h1);
        bus_wait(5, got, rd);
        bus_release();
        check("nohit_wr_ack", 32'(got), 32'h0);

        // held strobe: acks separated by a low cycle
        bus_drive(BASE | 32'hC, 1'b0, 32'h0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        bus_release();
        check("b2b_acks", 32'(acks), 32'h3);

        // unmapped and write-only reads
        wb_read(2, 32'h0, "data_read");
        wb_write(5, 32'hFFFF_FFFF);
        for (int s = 5; s < 8; s++) wb_read(s, 32'h0, "unmapped");

        // checksum
        wb_write(0, 32'h1);
        wb_write(2, 32'hFFFF_FFFF);
        wb_write(2, 32'h0000_0002);
        wait_drain();
`ifdef WB_MEM_LOADER_CSUM_EN
        check("csum_model", m_csum, 32'h1);
        wb_read(4, m_csum, "csum");
`else
        wb_read(4, 32'h0, "csum_absent");
`endif

        // randomized traffic
        set_ready(1'b1, 1'b0);
        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 9);
            if (r <= 5)      wb_write(2, $urandom);
            else if (r == 6) wb_write(1, $urandom);
            else if (r == 7) wb_write(0, {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            else if (r == 8) begin
                set_ready(1'b0, 1'b0);
                wb_read(3, m_status(), "rand_status");
                set_ready(1'b1, 1'b0);
            end else         wb_read(1, {12'b0, m_addr}, "rand_addr");
        end
        set_ready(1'b0, 1'b1);
        wait_drain();

        // reset in the middle of a load
        set_ready(1'b0, 1'b0);
        wb_write(0, 32'h1);
        for (int i = 0; i < 3; i++) wb_write(2, $urandom);
        @(negedge clk); #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(load_valid), 32'h0);
        check("midrst_loading", 32'(is_loading), 32'h0);
        check("midrst_reset_core", 32'(reset_core), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        #1 mon_en = 1'b1;
        p0 = pop_count;
        set_ready(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        wb_read(3, 32'h0000_0100, "status_after_rst");
        wb_read(1, 32'h0, "addr_after_rst");
        check("no_pop_after_rst", 32'(pop_count - p0), 32'h0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_mem_loader.md
WB_MEM_LOADER -- requirements
Module: wb_mem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, base of the Wishbone window; bits [4:0] ignored.
REQ-002 Parameter FIFO_DEPTH, default 4, load FIFO depth; power of two, 2..16.
REQ-003 clk  in  1  single clock; all logic synchronous to rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobe, cycle, write-enable.
REQ-006 wbs_sel_i  in  4  byte selects; all 4 set = full-word write; any other value on a write to DATA is treated as 4'hF.
REQ-007 wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-008 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-009 is_loading_memory_into_core  out  1  load-mode flag to the SRAM stage.
REQ-010 reset_core  out  1  active-high core hold-reset.
REQ-011 addr_to_core_mem  out  20  word address of the presented load word.
REQ-012 data_to_core_mem  out  32  presented load word.
REQ-013 load_valid  out  1  addr/data valid; load_ready  in  1  SRAM stage accepts this cycle.

Function
REQ-014 Hit = stb&cyc & (wbs_adr_i[31:5] == BASE_ADDR[31:5]); register select = wbs_adr_i[4:2].
REQ-015 Registers: 0 CTRL (rw; bit0 LOAD, bit1 HOLD), 1 ADDR (rw; [19:0] next load address), 2 DATA (wo; read returns 0), 3 STATUS (ro), 4 CSUM (REQ-031); unmapped selects read 0, ignore writes.
REQ-016 wbs_ack_o is registered: asserts exactly one cycle, the cycle after the hit is accepted, then deasserts for at least one cycle before the next ack.
REQ-017 Non-hit cycles never ack; wbs_dat_o = 0 whenever wbs_ack_o = 0.
REQ-018 DATA write while FIFO full is stalled: no ack, no push; accepted in the first cycle a slot is free.
REQ-019 DATA write pushes {ADDR, wbs_dat_i} into FIFO; ADDR increments by 1 mod 2^20 in the same cycle (0xFFFFF wraps to 0x00000).
REQ-020 DATA write with CTRL.LOAD = 0: acked, dropped, STATUS.DROP set (sticky, cleared by writing CTRL).
REQ-021 FIFO head drives load_valid/addr/data; pop when load_valid & load_ready; load_valid only while LOAD = 1 and FIFO non-empty.
REQ-022 Simultaneous push and pop when full: push accepted, occupancy unchanged; when empty: pop impossible, push only.
REQ-023 STATUS: [4:0] occupancy, bit8 empty, bit9 full, bit10 busy (= !empty), bit11 DROP.
REQ-024 is_loading_memory_into_core = CTRL.LOAD; reset_core = CTRL.HOLD | CTRL.LOAD.
REQ-025 Clearing CTRL.LOAD while FIFO non-empty: write acked, LOAD stays 1 until the FIFO drains, then falls (state DRAIN).
REQ-026 Control FSM: IDLE (LOAD=0) -> LOADING on CTRL write with bit0=1; LOADING -> DRAIN on CTRL write with bit0=0 and FIFO non-empty, -> IDLE if empty; DRAIN -> IDLE when FIFO empty; DATA writes in DRAIN are dropped per REQ-020.
REQ-027 ADDR writes are accepted any time; words already in the FIFO keep their captured addresses.

Reset
REQ-028 rst_n low asynchronously clears: FIFO (empty), ADDR = 0, CTRL.LOAD = 0, DROP = 0, ack = 0, FSM = IDLE, CSUM = 0.
REQ-029 CTRL.HOLD resets to 1, so reset_core = 1 out of reset; wbs_dat_o = 0, load_valid = 0.
REQ-030 Reset mid-load discards all FIFO contents; no partial word is presented after rst_n deasserts.

Configuration
REQ-031 Macro WB_MEM_LOADER_CSUM_EN defined: CSUM register = 32-bit wrapping sum of every popped data word, cleared on CTRL write with bit0 rising 0->1; undefined: CSUM logic absent, select 4 reads 0.

Verification
REQ-032 Reset release -> reset_core=1, is_loading=0, load_valid=0, STATUS=0x100.
REQ-033 CTRL<=1, ADDR<=0x00010, DATA<=0xDEADBEEF, load_ready=1 -> load_valid one cycle with addr 0x00010/data 0xDEADBEEF; ADDR reads 0x00011.
REQ-034 load_ready=0, 5 DATA writes (FIFO_DEPTH=4) -> 4 acked, 5th stalled, STATUS full; load_ready=1 -> 5th acked, 5 words emitted in order.
REQ-035 ADDR<=0xFFFFF, 2 DATA writes -> addresses 0xFFFFF then 0x00000.
REQ-036 3 words queued, load_ready=0, CTRL<=0 -> is_loading stays 1 until 3rd pop, then 0; DATA write meanwhile sets DROP.
REQ-037 With WB_MEM_LOADER_CSUM_EN, load 0xFFFFFFFF and 0x00000002 -> CSUM reads 0x00000001.
